// File: rtl/pad_out_seq_pkg.sv
// pad_out_seq_pkg: shared types for the pad output sequencer.
//   pad_out_mode_e  - requested drive mode carried on the configuration interface
//   pad_out_state_e - sequencer FSM state
//   attr_width()    - rounds a zero attribute width up to one bit
package pad_out_seq_pkg;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_LEVEL = 2'd1,
    MODE_CLOCK = 2'd2,
    MODE_BURST = 2'd3
  } pad_out_mode_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEVEL,
    ST_CLOCK,
    ST_BURST
  } pad_out_state_e;
  function automatic int attr_width(input int w);
    return (w == 0) ? 1 : w;
  endfunction
endpackage

// File: rtl/pad_out_seq_if.sv
// pad_out_seq_if: configuration handshake bundle for pad_out_sequencer.
//   cfg_valid_i/cfg_ready_o - request/accept handshake
//   cfg_mode_i, cfg_level_i, cfg_div_i, cfg_count_i, cfg_attr_i - captured on accept
//   master: configuration source; slave: the sequencer
interface pad_out_seq_if #(
  parameter int CNT_WIDTH = 16,
  parameter int ATTR_W    = 16
);
  import pad_out_seq_pkg::*;
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  pad_out_mode_e        cfg_mode_i;
  logic                 cfg_level_i;
  logic [CNT_WIDTH-1:0] cfg_div_i;
  logic [CNT_WIDTH-1:0] cfg_count_i;
  logic [ATTR_W-1:0]    cfg_attr_i;
  modport master (
    output cfg_valid_i, cfg_mode_i, cfg_level_i, cfg_div_i, cfg_count_i, cfg_attr_i,
    input  cfg_ready_o
  );
  modport slave (
    input  cfg_valid_i, cfg_mode_i, cfg_level_i, cfg_div_i, cfg_count_i, cfg_attr_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/pad_out_seq_timer.sv
// pad_out_seq_timer: loadable saturating down-counter with expiry flags.
//   clk_i, rst_ni - clock, async active-low reset (count cleared)
//   load_i, load_val_i - load has priority over decrement
//   dec_i - decrement by one; holds at zero instead of wrapping
//   expired_o - count is zero; last_o - count is one (expires on next decrement)
module pad_out_seq_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 expired_o,
  output logic                 last_o
);
  logic [CNT_WIDTH-1:0] cnt_q;
  assign expired_o = cnt_q == '0;
  assign last_o    = cnt_q == CNT_WIDTH'(1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (dec_i && !expired_o) cnt_q <= cnt_q - CNT_WIDTH'(1);
endmodule

// File: rtl/pad_out_sequencer.sv
// pad_out_sequencer: drives an output pad cell as off, static level, free clock or counted burst.
//   clk_i, rst_ni      - clock, async active-low reset
//   cfg                - configuration handshake (pad_out_seq_if.slave)
//   pad_in_o, pad_oe_o - registered value / output enable toward the pad cell
//   pad_attributes_o   - registered pad attributes from the last accepted configuration
//   busy_o             - in CLOCK or BURST; done_o - one-cycle pulse at burst completion
module pad_out_sequencer
  import pad_out_seq_pkg::*;
#(
  parameter int PADATTR   = 16,
  parameter int CNT_WIDTH = 16,
  localparam int PADATTR_RND = attr_width(PADATTR)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  pad_out_seq_if.slave           cfg,
  output logic                   pad_in_o,
  output logic                   pad_oe_o,
  output logic [PADATTR_RND-1:0] pad_attributes_o,
  output logic                   busy_o,
  output logic                   done_o
);
  pad_out_state_e       state_q, state_d;
  logic                 level_q, level_d;
  logic [CNT_WIDTH-1:0] div_q, div_d;
  logic [PADATTR_RND-1:0] attr_d;
  logic pad_d, oe_d, done_d, ready, accept, burst_empty;
  logic half_exp, half_last, pulse_exp, pulse_last;
  assign busy_o      = state_q == ST_CLOCK || state_q == ST_BURST;
  // Gating with rst_ni keeps ready low while reset is held, even though state reads IDLE.
  assign ready       = rst_ni && (state_q == ST_IDLE || state_q == ST_LEVEL ||
                       (state_q == ST_CLOCK && !pad_in_o && half_exp));
  assign cfg.cfg_ready_o = ready;
  assign accept      = cfg.cfg_valid_i && ready;
  assign burst_empty = cfg.cfg_count_i == '0;
  // Half-period timer: reloads on every expiry so each phase lasts div+1 cycles without wrap.
  pad_out_seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_half (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept || (busy_o && half_exp)),
    .load_val_i (accept ? cfg.cfg_div_i : div_q),
    .dec_i      (busy_o),
    .expired_o  (half_exp),
    .last_o     (half_last)
  );
  // Pulse timer: counts remaining pulses, decremented at the end of each high phase.
  pad_out_seq_timer #(.CNT_WIDTH(CNT_WIDTH)) u_pulse (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .load_val_i (cfg.cfg_count_i),
    .dec_i      (state_q == ST_BURST && pad_in_o && half_exp),
    .expired_o  (pulse_exp),
    .last_o     (pulse_last)
  );
  always_comb begin
    state_d = state_q;
    pad_d   = pad_in_o;
    oe_d    = pad_oe_o;
    attr_d  = pad_attributes_o;
    level_d = level_q;
    div_d   = div_q;
    done_d  = 1'b0;
    if (accept) begin
      level_d = cfg.cfg_level_i;
      div_d   = cfg.cfg_div_i;
      attr_d  = cfg.cfg_attr_i;
      oe_d    = cfg.cfg_mode_i != MODE_OFF;
      case (cfg.cfg_mode_i)
        MODE_OFF:   begin state_d = ST_IDLE;  pad_d = 1'b0; end
        MODE_LEVEL: begin state_d = ST_LEVEL; pad_d = cfg.cfg_level_i; end
        MODE_CLOCK: begin state_d = ST_CLOCK; pad_d = 1'b1; end
        default: begin
          state_d = burst_empty ? ST_LEVEL : ST_BURST;
          pad_d   = burst_empty ? cfg.cfg_level_i : 1'b1;
          done_d  = burst_empty;
        end
      endcase
    end else if (state_q == ST_CLOCK) begin
      pad_d = pad_in_o ^ half_exp;
    end else if (state_q == ST_BURST) begin
      pad_d   = pad_in_o ? !half_exp : (half_exp && (pulse_exp ? level_q : 1'b1));
      state_d = (!pad_in_o && half_exp && pulse_exp) ? ST_LEVEL : ST_BURST;
      // done_o must be high during the final low cycle, so it is armed one cycle ahead.
      done_d  = pad_in_o ? (half_exp && div_q == '0 && pulse_last) : (half_last && pulse_exp);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      pad_in_o         <= 1'b0;
      pad_oe_o         <= 1'b0;
      pad_attributes_o <= '0;
      done_o           <= 1'b0;
      level_q          <= 1'b0;
      div_q            <= '0;
    end else begin
      state_q          <= state_d;
      pad_in_o         <= pad_d;
      pad_oe_o         <= oe_d;
      pad_attributes_o <= attr_d;
      done_o           <= done_d;
      level_q          <= level_d;
      div_q            <= div_d;
    end
endmodule
